// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, shared by the ALU and load writebacks.
// The winning write is staged for one cycle, and read ports can bypass from that staged write.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] raddr_1,
  input  logic [ADDR_W-1:0] raddr_2,
  output logic              byp_hit_1,
  output logic              byp_hit_2,
  output logic [DATA_W-1:0] byp_data,
  output logic              reg_write,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              grant_id,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int NUM_RD = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  wb_req_t                      req0, req1, win;
  logic                         rr_last;
  logic                         both, grant, gid;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0]            hit;

  assign req0 = '{addr: req0_addr, data: req0_data};
  assign req1 = '{addr: req1_addr, data: req1_data};
  assign both = req0_valid & req1_valid;

  // Readies depend only on the valids and rr_last, never on each other.
  assign req0_ready = req0_valid & (~req1_valid | rr_last);
  assign req1_ready = req1_valid & (~req0_valid | ~rr_last);
  assign grant      = req0_ready | req1_ready;
  assign gid        = req1_ready;
  assign win        = gid ? req1 : req0;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_last      <= 1'b1;
      reg_write    <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      grant_id     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      reg_write <= grant;
      if (grant) begin
        waddr    <= win.addr;
        wdata    <= win.data;
        grant_id <= gid;
        rr_last  <= gid;
      end
      if (both && conflict_cnt != {CNT_W{1'b1}})
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  assign raddr = {raddr_2, raddr_1};

  for (genvar k = 0; k < NUM_RD; k++) begin : g_byp
    assign hit[k] = reg_write & (raddr[k] == waddr);
  end

  assign byp_hit_1 = hit[0];
  assign byp_hit_2 = hit[1];
  assign byp_data  = wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        req0_valid = 0, req1_valid = 0;
  logic [4:0]  req0_addr = 0, req1_addr = 0;
  logic [15:0] req0_data = 0, req1_data = 0;
  logic        req0_ready, req1_ready;
  logic [4:0]  raddr_1 = 0, raddr_2 = 0;
  logic        byp_hit_1, byp_hit_2;
  logic [15:0] byp_data;
  logic        reg_write;
  logic [4:0]  waddr;
  logic [15:0] wdata;
  logic        grant_id;
  logic [7:0]  conflict_cnt;

  int vecs = 0, errs = 0;

  // model state: who was served last, what is staged, how many conflicts seen
  int          m_last;
  bit          m_rw;
  logic [4:0]  m_waddr;
  logic [15:0] m_wdata;
  bit          m_gid;
  int          m_cnt;
  bit          m_r0, m_r1;

  regfile_wb_arbiter dut (
    .clk(clk), .arst_n(arst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .raddr_1(raddr_1), .raddr_2(raddr_2),
    .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2), .byp_data(byp_data),
    .reg_write(reg_write), .waddr(waddr), .wdata(wdata), .grant_id(grant_id),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // The winner is whoever is asking alone, or on a conflict whoever was not served last.
  function automatic void model_ready();
    int winner;
    winner = -1;
    if (req0_valid && req1_valid) winner = (m_last == 0) ? 1 : 0;
    else if (req0_valid)          winner = 0;
    else if (req1_valid)          winner = 1;
    m_r0 = (winner == 0);
    m_r1 = (winner == 1);
  endfunction

  task automatic model_reset();
    m_last = 1; m_rw = 0; m_waddr = 0; m_wdata = 0; m_gid = 0; m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    arst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    arst_n = 1;
    #1;
  endtask

  task automatic drive(input bit v0, input logic [4:0] a0, input logic [15:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [15:0] d1);
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    model_ready();
  endtask

  task automatic clock_edge();
    bit v0, v1;
    v0 = req0_valid; v1 = req1_valid;
    model_ready();
    @(posedge clk);
    if (m_r0 || m_r1) begin
      m_rw = 1; m_gid = m_r1;
      m_waddr = m_r1 ? req1_addr : req0_addr;
      m_wdata = m_r1 ? req1_data : req0_data;
      m_last = m_r1 ? 1 : 0;
    end else m_rw = 0;
    if (v0 && v1 && m_cnt < 255) m_cnt++;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (reg_write !== 1'b0) begin errs++; $display("FAIL reset_rw got %0b want 0", reg_write); end
    vecs++; if (waddr !== 5'd0 || wdata !== 16'd0 || grant_id !== 1'b0) begin errs++;
      $display("FAIL reset_stage got %0d/%h/%0b want 0/0000/0", waddr, wdata, grant_id); end
    vecs++; if (conflict_cnt !== 8'd0) begin errs++; $display("FAIL reset_cnt got %0d want 0", conflict_cnt); end
    vecs++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errs++;
      $display("FAIL reset_ready got %0b%0b want 00", req0_ready, req1_ready); end
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 5'd3, 16'h1234, 0, 5'd9, 16'hFFFF);
    vecs++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errs++;
      $display("FAIL single_ready got %0b%0b want 10", req0_ready, req1_ready); end
    clock_edge();
    vecs++; if (reg_write !== 1'b1 || waddr !== 5'd3 || wdata !== 16'h1234 || grant_id !== 1'b0) begin errs++;
      $display("FAIL single_stage got %0b/%0d/%h/%0b want 1/3/1234/0", reg_write, waddr, wdata, grant_id); end
    drive(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
    clock_edge();
    vecs++; if (reg_write !== 1'b0 || waddr !== 5'd3 || wdata !== 16'h1234) begin errs++;
      $display("FAIL single_hold got %0b/%0d/%h want 0/3/1234", reg_write, waddr, wdata); end
  endtask

  task automatic test_alternate();
    bit exp_gid[4] = '{0, 1, 0, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd1, 16'($urandom), 1, 5'd2, 16'($urandom));
      clock_edge();
      vecs++; if (reg_write !== 1'b1 || grant_id !== exp_gid[i] || waddr !== (exp_gid[i] ? 5'd2 : 5'd1)) begin errs++;
        $display("FAIL alternate_%0d got gid %0b addr %0d want gid %0b", i, grant_id, waddr, exp_gid[i]); end
    end
    vecs++; if (conflict_cnt !== 8'd4) begin errs++; $display("FAIL alternate_cnt got %0d want 4", conflict_cnt); end
  endtask

  task automatic test_same_addr();
    logic [15:0] reg5;
    do_reset();
    drive(1, 5'd5, 16'hAAAA, 1, 5'd5, 16'h5555);
    clock_edge();
    vecs++; if (grant_id !== 1'b0 || wdata !== 16'hAAAA) begin errs++;
      $display("FAIL same_first got %0b/%h want 0/aaaa", grant_id, wdata); end
    reg5 = wdata;
    drive(0, 5'd5, 16'hAAAA, 1, 5'd5, 16'h5555);
    clock_edge();
    if (reg_write && waddr == 5'd5) reg5 = wdata;
    vecs++; if (grant_id !== 1'b1 || reg5 !== 16'h5555) begin errs++;
      $display("FAIL same_final got %0b/%h want 1/5555", grant_id, reg5); end
  endtask

  task automatic test_bypass();
    do_reset();
    drive(0, 5'd0, 16'h0, 1, 5'd7, 16'hBEEF);
    clock_edge();
    raddr_1 = 5'd7; raddr_2 = 5'd8; #1;
    vecs++; if (byp_hit_1 !== 1'b1 || byp_hit_2 !== 1'b0 || byp_data !== 16'hBEEF) begin errs++;
      $display("FAIL bypass_hit got %0b%0b/%h want 10/beef", byp_hit_1, byp_hit_2, byp_data); end
    drive(0, 5'd0, 16'h0, 0, 5'd0, 16'h0);
    clock_edge();
    vecs++; if (byp_hit_1 !== 1'b0 || byp_hit_2 !== 1'b0) begin errs++;
      $display("FAIL bypass_idle got %0b%0b want 00", byp_hit_1, byp_hit_2); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1, 5'($urandom), 16'($urandom), 1, 5'($urandom), 16'($urandom));
      clock_edge();
      if (i == 254) begin
        vecs++; if (conflict_cnt !== 8'd255) begin errs++; $display("FAIL sat_reach got %0d want 255", conflict_cnt); end
      end
    end
    vecs++; if (conflict_cnt !== 8'd255 || reg_write !== 1'b1) begin errs++;
      $display("FAIL sat_hold got %0d/%0b want 255/1", conflict_cnt, reg_write); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd4, 16'h1111, 1, 5'd6, 16'h2222);
      clock_edge();
    end
    #2 arst_n = 0; model_reset(); #1;
    vecs++; if (reg_write !== 1'b0 || conflict_cnt !== 8'd0) begin errs++;
      $display("FAIL midrst_clear got %0b/%0d want 0/0", reg_write, conflict_cnt); end
    vecs++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errs++;
      $display("FAIL midrst_ready got %0b%0b want 10", req0_ready, req1_ready); end
    @(negedge clk); arst_n = 1; #1;
    clock_edge();
    vecs++; if (reg_write !== 1'b1 || grant_id !== 1'b0 || waddr !== 5'd4) begin errs++;
      $display("FAIL midrst_first got %0b/%0b/%0d want 1/0/4", reg_write, grant_id, waddr); end
  endtask

  task automatic test_random();
    bit p0 = 0, p1 = 0;
    logic [4:0] a0 = 0, a1 = 0;
    logic [15:0] d0 = 0, d1 = 0;
    logic exp_h1, exp_h2;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!p0 && ($urandom % 3) != 0) begin p0 = 1; a0 = 5'($urandom); d0 = 16'($urandom); end
      if (!p1 && ($urandom % 3) != 0) begin p1 = 1; a1 = 5'($urandom); d1 = 16'($urandom); end
      drive(p0, a0, d0, p1, a1, d1);
      vecs++; if (req0_ready !== m_r0 || req1_ready !== m_r1) begin errs++;
        $display("FAIL rand_ready_%0d got %0b%0b want %0b%0b", i, req0_ready, req1_ready, m_r0, m_r1); end
      if (m_r0) p0 = 0;
      if (m_r1) p1 = 0;
      clock_edge();
      raddr_1 = ($urandom % 2) ? m_waddr : 5'($urandom);
      raddr_2 = ($urandom % 2) ? m_waddr : 5'($urandom);
      #1;
      exp_h1 = m_rw && (raddr_1 == m_waddr);
      exp_h2 = m_rw && (raddr_2 == m_waddr);
      vecs++; if (reg_write !== m_rw || waddr !== m_waddr || wdata !== m_wdata || grant_id !== m_gid) begin errs++;
        $display("FAIL rand_stage_%0d got %0b/%0d/%h/%0b want %0b/%0d/%h/%0b", i, reg_write, waddr, wdata, grant_id,
                 m_rw, m_waddr, m_wdata, m_gid); end
      vecs++; if (conflict_cnt !== 8'(m_cnt)) begin errs++;
        $display("FAIL rand_cnt_%0d got %0d want %0d", i, conflict_cnt, m_cnt); end
      vecs++; if (byp_hit_1 !== exp_h1 || byp_hit_2 !== exp_h2 || byp_data !== m_wdata) begin errs++;
        $display("FAIL rand_byp_%0d got %0b%0b/%h want %0b%0b/%h", i, byp_hit_1, byp_hit_2, byp_data,
                 exp_h1, exp_h2, m_wdata); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_same_addr();
    test_bypass();
    test_saturate();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
